// File: rtl/six_bit_serializer.sv
// Parallel-in, serial-out stage: takes a word over load/ready and drives it one
// bit per clock on w, with optional even parity and back-to-back frame reload.
module six_bit_serializer #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY    = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             w,
  output logic             wvalid,
  output logic             done,
  output logic             busy
);

  localparam int FL = WIDTH + (PARITY ? 1 : 0);
  localparam int CW = (FL > 1) ? $clog2(FL) : 1;
  localparam logic [CW-1:0] LAST = CW'(FL - 1);
  localparam logic [CW-1:0] PIDX = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign wvalid = busy;
  assign done   = busy && (cnt_q == LAST);
  assign ready  = (state_q == IDLE) || done;

  // The parity slot follows the data bits; the shift register is ignored there.
  always_comb begin
    w = 1'b0;
    if (busy) begin
      if (PARITY && (cnt_q == PIDX)) w = par_q;
      else                           w = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (load && ready) begin
      state_d = SHIFT;
      sreg_d  = din;
      par_d   = ^din;
      cnt_d   = '0;
    end else if (done) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      par_d   = 1'b0;
    end else if (busy) begin
      cnt_d  = cnt_q + CW'(1);
      sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
    end
  end

endmodule

// File: tb/tb_six_bit_serializer.sv
// Bench for six_bit_serializer: default, parity and LSB-first instances driven
// by directed steps, with expected bits queued at load time and popped per cycle.
module tb_six_bit_serializer;
  logic       clk = 1'b0;
  logic       clr;
  logic [5:0] din;
  logic [2:0] ld;
  logic [2:0] w, wv, dn, rdy, bsy;
  logic [5:0] q_ds;

  int passed = 0;
  int total  = 0;

  typedef struct {logic w; logic done;} bit_t;
  bit_t exp_q[$];

  always #5 clk = ~clk;

  six_bit_serializer #(.WIDTH(6), .MSB_FIRST(1'b1), .PARITY(1'b0)) dut_def (
    .clk(clk), .clr(clr), .din(din), .load(ld[0]), .ready(rdy[0]),
    .w(w[0]), .wvalid(wv[0]), .done(dn[0]), .busy(bsy[0]));
  six_bit_serializer #(.WIDTH(6), .MSB_FIRST(1'b1), .PARITY(1'b1)) dut_par (
    .clk(clk), .clr(clr), .din(din), .load(ld[1]), .ready(rdy[1]),
    .w(w[1]), .wvalid(wv[1]), .done(dn[1]), .busy(bsy[1]));
  six_bit_serializer #(.WIDTH(6), .MSB_FIRST(1'b0), .PARITY(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .din(din), .load(ld[2]), .ready(rdy[2]),
    .w(w[2]), .wvalid(wv[2]), .done(dn[2]), .busy(bsy[2]));

  // Downstream 6-bit shift register fed by the default instance.
  always @(posedge clk) if (wv[0]) q_ds <= {q_ds[4:0], w[0]};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [5:0] d, input bit msb, input bit par);
    int   fl;
    int   ones;
    bit_t e;
    fl   = par ? 7 : 6;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      e.w    = msb ? d[5-i] : d[i];
      e.done = (i == fl - 1);
      if (e.w) ones++;
      exp_q.push_back(e);
    end
    if (par) begin
      e.w    = (ones % 2) == 1;
      e.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic start(input int sel, input logic [5:0] d, input bit hold);
    din     = d;
    ld[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) ld[sel] = 1'b0;
  endtask

  // act 1: drop load after next edge; act 2: mid-frame load attempt; act 3: async reset.
  task automatic drain(input int sel, input string tag, input int act_at, input int act,
                       input logic [5:0] d2);
    int   n;
    int   i;
    bit_t e;
    n = 0;
    @(negedge clk);
    while (!wv[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start"}, {7'd0, wv[sel]}, 8'd1);
    if (!wv[sel]) begin
      exp_q.delete();
      return;
    end
    i = 0;
    while (exp_q.size() > 0) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s w[%0d]", tag, i),      {7'd0, w[sel]},   {7'd0, e.w});
      chk($sformatf("%s wvalid[%0d]", tag, i), {7'd0, wv[sel]},  8'd1);
      chk($sformatf("%s done[%0d]", tag, i),   {7'd0, dn[sel]},  {7'd0, e.done});
      chk($sformatf("%s ready[%0d]", tag, i),  {7'd0, rdy[sel]}, {7'd0, e.done});
      chk($sformatf("%s busy[%0d]", tag, i),   {7'd0, bsy[sel]}, 8'd1);
      if (i == act_at) begin
        if (act == 1) begin
          @(posedge clk);
          #1;
          ld[sel] = 1'b0;
        end else if (act == 2) begin
          din     = d2;
          ld[sel] = 1'b1;
          @(posedge clk);
          #1;
          ld[sel] = 1'b0;
        end else if (act == 3) begin
          #2;
          clr = 1'b0;
          #1;
          chk({tag, " rst w"},      {7'd0, w[sel]},   8'd0);
          chk({tag, " rst wvalid"}, {7'd0, wv[sel]},  8'd0);
          chk({tag, " rst busy"},   {7'd0, bsy[sel]}, 8'd0);
          chk({tag, " rst done"},   {7'd0, dn[sel]},  8'd0);
          chk({tag, " rst ready"},  {7'd0, rdy[sel]}, 8'd1);
          exp_q.delete();
          @(posedge clk);
          #1;
          clr = 1'b1;
          return;
        end
      end
      i++;
    end
    @(negedge clk);
    chk({tag, " idle wvalid"}, {7'd0, wv[sel]},  8'd0);
    chk({tag, " idle ready"},  {7'd0, rdy[sel]}, 8'd1);
    chk({tag, " idle w"},      {7'd0, w[sel]},   8'd0);
    chk({tag, " idle busy"},   {7'd0, bsy[sel]}, 8'd0);
  endtask

  initial begin
    clr = 1'b0;
    ld  = 3'b000;
    din = 6'd0;
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset w%0d", s),      {7'd0, w[s]},   8'd0);
      chk($sformatf("reset wvalid%0d", s), {7'd0, wv[s]},  8'd0);
      chk($sformatf("reset done%0d", s),   {7'd0, dn[s]},  8'd0);
      chk($sformatf("reset busy%0d", s),   {7'd0, bsy[s]}, 8'd0);
      chk($sformatf("reset ready%0d", s),  {7'd0, rdy[s]}, 8'd1);
    end
    @(posedge clk);
    #1;
    clr = 1'b1;

    // Single frame and downstream word.
    push_frame(6'b101101, 1'b1, 1'b0);
    start(0, 6'b101101, 1'b0);
    drain(0, "t1", -1, 0, 6'd0);
    chk("t1 Q", {2'd0, q_ds}, 8'b00101101);

    // Back-to-back frames with load held through the done cycle.
    push_frame(6'b111000, 1'b1, 1'b0);
    push_frame(6'b000111, 1'b1, 1'b0);
    start(0, 6'b111000, 1'b1);
    din = 6'b000111;
    drain(0, "t2", 5, 1, 6'd0);
    chk("t2 Q", {2'd0, q_ds}, 8'b00000111);

    // Mid-frame load is ignored.
    push_frame(6'b010101, 1'b1, 1'b0);
    start(0, 6'b010101, 1'b0);
    drain(0, "t3", 1, 2, 6'b110011);

    // Asynchronous reset during bit 3, then a fresh frame.
    push_frame(6'b111111, 1'b1, 1'b0);
    start(0, 6'b111111, 1'b0);
    drain(0, "t4a", 2, 3, 6'd0);
    push_frame(6'b000001, 1'b1, 1'b0);
    start(0, 6'b000001, 1'b0);
    drain(0, "t4b", -1, 0, 6'd0);

    // Even parity appended.
    push_frame(6'b000111, 1'b1, 1'b1);
    start(1, 6'b000111, 1'b0);
    drain(1, "t5a", -1, 0, 6'd0);
    push_frame(6'b000011, 1'b1, 1'b1);
    start(1, 6'b000011, 1'b0);
    drain(1, "t5b", -1, 0, 6'd0);

    // LSB first.
    push_frame(6'b000001, 1'b0, 1'b0);
    start(2, 6'b000001, 1'b0);
    drain(2, "t6", -1, 0, 6'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
